fpu_addsub_pipe: RTL and testbench

//   Parametrised IEEE-754-style floating-point adder/subtractor. Successor to the fixed fp32 subtractor.

---
 rtl/fpu_pkg.sv | 34 +++
 rtl/fpu_addsub_pipe_if.sv | 31 +++
 rtl/fpu_lzc.sv | 22 ++
 rtl/fpu_addsub_pipe.sv | 196 +++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add/subtract pipeline.
// Widths that depend on EXP_W/MAN_W live in the module; this package holds the width-independent parts.
package fpu_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  localparam logic [31:0] QNAN_FP32 = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_NAN,
    TAG_INVALID,
    TAG_INF,
    TAG_ZERO
  } tag_e;

  function automatic int bias(int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits: exponent all ones, top mantissa bit set.
  function automatic logic [63:0] qnan_word(int exp_w, int man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w = w | (64'd1 << (man_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/fpu_addsub_pipe_if.sv
// Operand/result handshake bundle for the add/subtract pipeline.
// The master side drives operands and out_ready; the slave side is the arithmetic block.
interface fpu_addsub_pipe_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [2:0]   flags;

  modport master (
    output in_valid, op_sub, x1, x2, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, op_sub, x1, x2, out_ready,
    output in_ready, out_valid, y, flags
  );

endinterface

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; count equals WIDTH when the input is all zeros.
module fpu_lzc #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0]               in_vec,
  output logic [$clog2(WIDTH+1)-1:0]     count,
  output logic                           all_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  always_comb begin
    count    = CNT_W'(WIDTH);
    all_zero = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (in_vec[i]) begin
        count    = CNT_W'(WIDTH - 1 - i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fpu_addsub_pipe.sv
// Pipelined IEEE-754 style add/subtract: align, add/normalise, round/pack.
// All three stages share one enable, so a stalled result freezes the whole pipe without collapsing bubbles.
module fpu_addsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic              clk,
  input logic              rst,
  fpu_addsub_pipe_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int F    = MAN_W + 4;
  localparam int XE   = EXP_W + 2;
  localparam int SH_W = $clog2(F);
  localparam int LZW  = $clog2(F + 1);
  localparam logic [W-1:0]         QNAN    = W'(qnan_word(EXP_W, MAN_W));
  localparam logic signed [XE-1:0] EXP_MAX = XE'((1 << EXP_W) - 1);

  typedef struct packed {
    logic             valid;
    tag_e             tag;
    logic             sign;
    logic             eff_sub;
    logic [EXP_W-1:0] exp;
    logic [F-1:0]     mant_a;
    logic [F-1:0]     mant_b;
  } s1_t;

  typedef struct packed {
    logic                  valid;
    tag_e                  tag;
    logic                  sign;
    logic signed [XE-1:0]  exp;
    logic [F-1:0]          mant;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [W-1:0] y_d, y_q;
  logic [2:0]   flags_d, flags_q;
  logic         out_valid_d, out_valid_q;
  logic         en;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [W-2:0]     mag_a, mag_b, mag_big, mag_small;
  logic             swap;
  logic [EXP_W-1:0] exp_diff;
  logic [SH_W-1:0]  shamt;
  logic [F-1:0]     mant_small;
  logic             sticky;

  logic [F:0]       sum;
  logic [LZW-1:0]   lz;
  logic             sum_zero;

  logic             round_inc;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac;
  logic [XE-1:0]    exp_r;

  assign en             = ~out_valid_q | bus.out_ready;
  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid_q;
  assign bus.y          = y_q;
  assign bus.flags      = flags_q;

  assign sa = bus.x1[W-1];
  assign ea = bus.x1[W-2:MAN_W];
  assign ma = bus.x1[MAN_W-1:0];
  assign sb = bus.x2[W-1] ^ bus.op_sub;
  assign eb = bus.x2[W-2:MAN_W];
  assign mb = bus.x2[MAN_W-1:0];

  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_zero = ~(|ea);
  assign b_zero = ~(|eb);

  // Stage 1: flush denormals, order operands by magnitude, right-align the smaller one.
  always_comb begin
    mag_a      = a_zero ? '0 : bus.x1[W-2:0];
    mag_b      = b_zero ? '0 : bus.x2[W-2:0];
    swap       = mag_b > mag_a;
    mag_big    = swap ? mag_b : mag_a;
    mag_small  = swap ? mag_a : mag_b;
    exp_diff   = mag_big[W-2:MAN_W] - mag_small[W-2:MAN_W];
    shamt      = (int'(exp_diff) >= MAN_W + 3) ? SH_W'(MAN_W + 3) : SH_W'(exp_diff);
    mant_small = {|mag_small[W-2:MAN_W], mag_small[MAN_W-1:0], 3'b000};
    sticky     = |(mant_small & ~({F{1'b1}} << shamt));

    s1_d         = '0;
    s1_d.valid   = bus.in_valid;
    s1_d.sign    = swap ? sb : sa;
    s1_d.eff_sub = sa ^ sb;
    s1_d.exp     = mag_big[W-2:MAN_W];
    s1_d.mant_a  = {|mag_big[W-2:MAN_W], mag_big[MAN_W-1:0], 3'b000};
    s1_d.mant_b  = (mant_small >> shamt) | {{(F-1){1'b0}}, sticky};
    s1_d.tag     = TAG_NONE;

    if (a_nan | b_nan) begin
      s1_d.tag = TAG_NAN;
    end else if (a_inf & b_inf & (sa ^ sb)) begin
      s1_d.tag = TAG_INVALID;
    end else if (a_inf | b_inf) begin
      s1_d.tag  = TAG_INF;
      s1_d.sign = a_inf ? sa : sb;
    end else if (a_zero & b_zero) begin
      s1_d.tag  = TAG_ZERO;
      s1_d.sign = sa & sb;
    end
  end

  assign sum = s1_q.eff_sub ? ({1'b0, s1_q.mant_a} - {1'b0, s1_q.mant_b})
                            : ({1'b0, s1_q.mant_a} + {1'b0, s1_q.mant_b});

  fpu_lzc #(.WIDTH(F)) u_lzc (
    .in_vec   (sum[F-1:0]),
    .count    (lz),
    .all_zero (sum_zero)
  );

  // Stage 2: a carry renormalises right by one keeping the lost bit sticky, otherwise shift left by lz.
  always_comb begin
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.tag   = s1_q.tag;
    s2_d.sign  = s1_q.sign;
    if (sum[F]) begin
      s2_d.mant = {sum[F:2], |sum[1:0]};
      s2_d.exp  = XE'(s1_q.exp) + XE'(1);
    end else begin
      s2_d.mant = sum[F-1:0] << lz;
      s2_d.exp  = XE'(s1_q.exp) - XE'(lz);
    end
    if ((s1_q.tag == TAG_NONE) && sum_zero && !sum[F]) begin
      s2_d.tag  = TAG_ZERO;
      s2_d.sign = 1'b0;
    end
  end

  // Stage 3: round to nearest even on guard with round|sticky, then range-check and pack.
  always_comb begin
    round_inc   = s2_q.mant[2] & (s2_q.mant[3] | s2_q.mant[1] | s2_q.mant[0]);
    rounded     = {1'b0, s2_q.mant[F-1:3]} + {{(MAN_W+1){1'b0}}, round_inc};
    frac        = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    exp_r       = s2_q.exp + {{(XE-1){1'b0}}, rounded[MAN_W+1]};
    y_d         = '0;
    flags_d     = '0;
    out_valid_d = s2_q.valid;

    case (s2_q.tag)
      TAG_NAN: y_d = QNAN;
      TAG_INVALID: begin
        y_d                   = QNAN;
        flags_d[FLAG_INVALID] = 1'b1;
      end
      TAG_INF:  y_d = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      TAG_ZERO: y_d = {s2_q.sign, {(W-1){1'b0}}};
      default: begin
        if ($signed(exp_r) >= EXP_MAX) begin
          y_d                    = {s2_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d[FLAG_OVERFLOW] = 1'b1;
        end else if ($signed(exp_r) <= 0) begin
          y_d                     = {s2_q.sign, {(W-1){1'b0}}};
          flags_d[FLAG_UNDERFLOW] = 1'b1;
        end else begin
          y_d = {s2_q.sign, exp_r[EXP_W-1:0], frac};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      y_q         <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      y_q         <= y_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Directed bench for fpu_addsub_pipe: fp32 arithmetic, rounding, specials, stalls, reset flush,
// plus a double-precision instance sharing the clock and reset.
module tb_fpu_addsub_pipe;
  import fpu_pkg::*;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [2:0]  f;
    string       name;
  } vec_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  fpu_addsub_pipe_if #(.EXP_W(8),  .MAN_W(23)) b32 ();
  fpu_addsub_pipe_if #(.EXP_W(11), .MAN_W(52)) b64 ();

  fpu_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  fpu_addsub_pipe #(.EXP_W(11), .MAN_W(52)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents one fp32 op at posedge+1 and returns once out_valid is seen (lat counts edges from accept).
  task automatic run_op32(input logic sub, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] y, output logic [2:0] f, output int lat);
    int guard = 0;
    b32.in_valid = 1'b1;
    b32.op_sub   = sub;
    b32.x1       = a;
    b32.x2       = b;
    #1;
    while (!b32.in_ready && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    lat = 1;
    while (!b32.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    y = b32.y;
    f = b32.flags;
  endtask

  task automatic run_op64(input logic sub, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] y, output logic [2:0] f, output int lat);
    b64.in_valid = 1'b1;
    b64.op_sub   = sub;
    b64.x1       = a;
    b64.x2       = b;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    lat = 1;
    while (!b64.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    y = b64.y;
    f = b64.flags;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b32.in_valid = 1'b0; b32.out_ready = 1'b1; b32.op_sub = 1'b0; b32.x1 = '0; b32.x2 = '0;
    b64.in_valid = 1'b0; b64.out_ready = 1'b1; b64.op_sub = 1'b0; b64.x1 = '0; b64.x2 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (b32.out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset out_valid: got %b expected 0", b32.out_valid); end
    checks++;
    if (b32.y !== 32'h0) begin fails++; $display("[TB] FAIL reset y: got %h expected 00000000", b32.y); end
    checks++;
    if (b32.flags !== 3'b000) begin fails++; $display("[TB] FAIL reset flags: got %b expected 000", b32.flags); end
    checks++;
    if (b32.in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset in_ready: got %b expected 1", b32.in_ready); end
    checks++;
    if (b64.out_valid !== 1'b0 || b64.y !== 64'h0) begin
      fails++; $display("[TB] FAIL reset64: got valid %b y %h expected 0 and 0", b64.out_valid, b64.y);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    logic [31:0] y;
    logic [2:0]  f;
    int          lat;
    run_op32(1'b0, 32'h3F80_0000, 32'h3F80_0000, y, f, lat);
    checks++;
    if (lat !== 3) begin fails++; $display("[TB] FAIL add latency: got %0d expected 3", lat); end
    checks++;
    if (y !== 32'h4000_0000) begin fails++; $display("[TB] FAIL add y: got %h expected 40000000", y); end
    checks++;
    if (f !== 3'b000) begin fails++; $display("[TB] FAIL add flags: got %b expected 000", f); end
  endtask

  task automatic test_arith();
    vec_t        v[$];
    logic [31:0] y;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000, "one_minus_one"});
    v.push_back('{1'b0, 32'hC040_0000, 32'h3FC0_0000, 32'hBFC0_0000, 3'b000, "neg3_plus_1p5"});
    v.push_back('{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000, "negzero_sum"});
    v.push_back('{1'b0, 32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 3'b000, "denorm_flush"});
    v.push_back('{1'b1, 32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 3'b001, "underflow"});
    foreach (v[i]) begin
      run_op32(v[i].sub, v[i].a, v[i].b, y, f, lat);
      checks++;
      if (y !== v[i].y) begin fails++; $display("[TB] FAIL %s y: got %h expected %h", v[i].name, y, v[i].y); end
      checks++;
      if (f !== v[i].f) begin fails++; $display("[TB] FAIL %s flags: got %b expected %b", v[i].name, f, v[i].f); end
    end
  endtask

  task automatic test_round();
    vec_t        v[$];
    logic [31:0] y;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3'b000, "rne_tie_even"});
    v.push_back('{1'b0, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 3'b000, "rne_tie_odd"});
    foreach (v[i]) begin
      run_op32(v[i].sub, v[i].a, v[i].b, y, f, lat);
      checks++;
      if (y !== v[i].y) begin fails++; $display("[TB] FAIL %s y: got %h expected %h", v[i].name, y, v[i].y); end
      checks++;
      if (f !== v[i].f) begin fails++; $display("[TB] FAIL %s flags: got %b expected %b", v[i].name, f, v[i].f); end
    end
  endtask

  task automatic test_special();
    vec_t        v[$];
    logic [31:0] y;
    logic [2:0]  f;
    int          lat;
    v.push_back('{1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 3'b010, "overflow"});
    v.push_back('{1'b1, 32'h7F80_0000, 32'h7F80_0000, QNAN_FP32,     3'b100, "inf_minus_inf"});
    v.push_back('{1'b0, 32'h7FC0_0001, 32'h3F80_0000, QNAN_FP32,     3'b000, "nan_in"});
    v.push_back('{1'b1, 32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 3'b000, "one_minus_inf"});
    foreach (v[i]) begin
      run_op32(v[i].sub, v[i].a, v[i].b, y, f, lat);
      checks++;
      if (y !== v[i].y) begin fails++; $display("[TB] FAIL %s y: got %h expected %h", v[i].name, y, v[i].y); end
      checks++;
      if (f !== v[i].f) begin fails++; $display("[TB] FAIL %s flags: got %b expected %b", v[i].name, f, v[i].f); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa[4];
    logic [31:0] xb[4];
    logic [31:0] ey[4];
    logic        sb[4];
    int          sent = 0;
    int          got  = 0;
    logic        accepted;
    xa = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h3FC0_0000};
    xb = '{32'h3F80_0000, 32'h3F80_0000, 32'h4080_0000, 32'h3F00_0000};
    ey = '{32'h4000_0000, 32'h4040_0000, 32'h4100_0000, 32'h3F80_0000};
    sb = '{1'b0, 1'b0, 1'b0, 1'b1};
    b32.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      b32.out_ready = (cyc >= 8);
      if (sent < 4) begin
        b32.in_valid = 1'b1;
        b32.op_sub   = sb[sent];
        b32.x1       = xa[sent];
        b32.x2       = xb[sent];
      end else begin
        b32.in_valid = 1'b0;
      end
      #1;
      if (cyc >= 3 && cyc < 8) begin
        checks++;
        if (b32.in_ready !== 1'b0) begin
          fails++; $display("[TB] FAIL stall in_ready cycle %0d: got %b expected 0", cyc, b32.in_ready);
        end
        checks++;
        if (b32.out_valid !== 1'b1 || b32.y !== ey[0]) begin
          fails++; $display("[TB] FAIL stall hold cycle %0d: got valid %b y %h expected 1 %h", cyc, b32.out_valid, b32.y, ey[0]);
        end
      end
      if (b32.out_valid && b32.out_ready) begin
        checks++;
        if (b32.y !== ey[got] || cyc !== 8 + got) begin
          fails++; $display("[TB] FAIL drain %0d: got y %h at cycle %0d expected %h at cycle %0d", got, b32.y, cyc, ey[got], 8 + got);
        end
        got++;
      end
      accepted = b32.in_valid & b32.in_ready;
      @(posedge clk); #1;
      if (accepted) sent++;
    end
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    checks++;
    if (got !== 4 || sent !== 4) begin
      fails++; $display("[TB] FAIL b2b count: got sent %0d received %0d expected 4 and 4", sent, got);
    end
  endtask

  task automatic test_reset_flush();
    logic [31:0] xa[3];
    logic [31:0] y;
    logic [2:0]  f;
    int          lat;
    int          stale = 0;
    xa = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000};
    b32.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      b32.in_valid = 1'b1;
      b32.op_sub   = 1'b0;
      b32.x1       = xa[k];
      b32.x2       = xa[k];
      @(posedge clk); #1;
    end
    b32.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (b32.out_valid !== 1'b0 || b32.y !== 32'h0 || b32.flags !== 3'b000) begin
      fails++; $display("[TB] FAIL flush: got valid %b y %h flags %b expected 0 00000000 000", b32.out_valid, b32.y, b32.flags);
    end
    rst = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b32.out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin fails++; $display("[TB] FAIL stale results: got %0d expected 0", stale); end
    run_op32(1'b0, 32'h3F80_0000, 32'h4000_0000, y, f, lat);
    checks++;
    if (y !== 32'h4040_0000 || lat !== 3) begin
      fails++; $display("[TB] FAIL post-reset op: got y %h latency %0d expected 40400000 3", y, lat);
    end
  endtask

  task automatic test_double();
    logic [63:0] one64;
    logic [63:0] two64;
    logic [63:0] y;
    logic [2:0]  f;
    int          lat;
    one64 = 64'(bias(11)) << 52;
    two64 = 64'(bias(11) + 1) << 52;
    run_op64(1'b0, one64, two64, y, f, lat);
    checks++;
    if (y !== 64'h4008_0000_0000_0000) begin fails++; $display("[TB] FAIL dp add y: got %h expected 4008000000000000", y); end
    checks++;
    if (f !== 3'b000 || lat !== 3) begin fails++; $display("[TB] FAIL dp add flags/latency: got %b %0d expected 000 3", f, lat); end
    run_op64(1'b1, two64, one64, y, f, lat);
    checks++;
    if (y !== 64'h3FF0_0000_0000_0000) begin fails++; $display("[TB] FAIL dp sub y: got %h expected 3ff0000000000000", y); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_round();
    test_special();
    test_back_to_back();
    test_reset_flush();
    test_double();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
